// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (radix-2 Booth) and divide (restoring)
// engine that borrows an external ADD/SUB ALU for every arithmetic step.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_inA,
  output logic [31:0] alu_inB,
  input  logic [31:0] alu_result,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [4:0]    OP_ADD   = 5'b00000;
  localparam logic [4:0]    OP_SUB   = 5'b00001;
  localparam logic [CW-1:0] ITER_END = CW'(W);
  localparam logic [W-1:0]  INT_MIN  = 32'h8000_0000;
  localparam logic [W-1:0]  NEG_ONE  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  p_hi;   // Booth upper product / divide partial remainder
  logic [W-1:0]  p_lo;   // Booth multiplier bits / divide dividend->quotient
  logic          p_q;    // Booth q-1
  logic [W-1:0]  mcand;  // multiplicand or divisor magnitude
  logic          neg_q;
  logic          div_ovf;

  logic [W-1:0]  div_rem_c;
  logic [W-1:0]  abs_a_c;
  logic [W-1:0]  abs_b_c;
  logic [W-1:0]  mul_hi_c;
  logic [W-1:0]  mul_lo_c;
  logic [CW-1:0] cnt_nxt_c;
  logic          alu_ovf_c;
  logic          res_sign_c;
  logic          div_borrow_c;

  // Shared ALU steering per state
  always_comb begin
    alu_opcode = OP_ADD;
    alu_inA    = '0;
    alu_inB    = '0;
    div_rem_c  = {p_hi[W-2:0], p_lo[W-1]};
    case (state)
      MUL: begin
        alu_inA = p_hi;
        case ({p_lo[0], p_q})
          2'b01:   alu_inB = mcand;
          2'b10: begin
            alu_opcode = OP_SUB;
            alu_inB    = mcand;
          end
          default: alu_inB = '0;
        endcase
      end
      DIV: begin
        alu_opcode = OP_SUB;
        alu_inA    = div_rem_c;
        alu_inB    = mcand;
      end
      FIXUP: begin
        alu_opcode = neg_q ? OP_SUB : OP_ADD;
        alu_inB    = p_lo;
      end
      default: ;
    endcase
  end

  // Step helpers; the Booth shift takes the true sign so a -2^31 multiplicand cannot wrap
  always_comb begin
    if (alu_opcode == OP_SUB)
      alu_ovf_c = (alu_inA[W-1] != alu_inB[W-1]) && (alu_result[W-1] != alu_inA[W-1]);
    else
      alu_ovf_c = (alu_inA[W-1] == alu_inB[W-1]) && (alu_result[W-1] != alu_inA[W-1]);
    res_sign_c   = alu_result[W-1] ^ alu_ovf_c;
    mul_hi_c     = {res_sign_c, alu_result[W-1:1]};
    mul_lo_c     = {alu_result[0], p_lo[W-1:1]};
    div_borrow_c = (~alu_inA[W-1] & alu_inB[W-1]) |
                   (~(alu_inA[W-1] ^ alu_inB[W-1]) & alu_result[W-1]);
    cnt_nxt_c    = cnt + CW'(1);
    abs_a_c      = data_operandA[W-1] ? (~data_operandA) + W'(1) : data_operandA;
    abs_b_c      = data_operandB[W-1] ? (~data_operandB) + W'(1) : data_operandB;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      p_hi           <= '0;
      p_lo           <= '0;
      p_q            <= 1'b0;
      mcand          <= '0;
      neg_q          <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT) begin
            mcand <= data_operandA;
            p_hi  <= '0;
            p_lo  <= data_operandB;
            p_q   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end else if (ctrl_DIV) begin
            if (data_operandB == '0) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end else begin
              mcand   <= abs_b_c;
              p_hi    <= '0;
              p_lo    <= abs_a_c;
              neg_q   <= data_operandA[W-1] ^ data_operandB[W-1];
              div_ovf <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= DIV;
            end
          end
        end
        MUL: begin
          p_hi <= mul_hi_c;
          p_lo <= mul_lo_c;
          p_q  <= p_lo[0];
          cnt  <= cnt_nxt_c;
          if (cnt_nxt_c == ITER_END) begin
            data_result    <= mul_lo_c;
            data_exception <= (mul_hi_c != {W{mul_lo_c[W-1]}});
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end
        end
        DIV: begin
          p_hi <= div_borrow_c ? div_rem_c : alu_result;
          p_lo <= {p_lo[W-2:0], ~div_borrow_c};
          cnt  <= cnt_nxt_c;
          if (cnt_nxt_c == ITER_END)
            state <= FIXUP;
        end
        FIXUP: begin
          data_result    <= div_ovf ? '0 : alu_result;
          data_exception <= div_ovf;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= DONE;
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed and random multiply/divide
// against a plain-arithmetic reference, with latency, busy and reset checks.
module tb_multdiv_seq;

  localparam int NEDGE = 40;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_inA;
  logic [31:0] alu_inB;
  logic [31:0] alu_result;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors;
  int miscompares;

  logic        obs_rdy  [1:NEDGE];
  logic        obs_busy [1:NEDGE];
  logic [31:0] obs_res  [1:NEDGE];
  logic        obs_exc  [1:NEDGE];

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_opcode     (alu_opcode),
    .alu_inA        (alu_inA),
    .alu_inB        (alu_inB),
    .alu_result     (alu_result),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // External ALU: 00001 subtracts, anything else adds
  assign alu_result = (alu_opcode == 5'b00001) ? alu_inA - alu_inB : alu_inA + alu_inB;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {p[31:0], (p[63:32] != {32{p[31]}})};
  endfunction

  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    if (b == 32'd0) return {32'd0, 1'b1};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 1'b1};
    q = $signed(a) / $signed(b);
    return {q, 1'b0};
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd0;
      3: v = 32'($urandom_range(1, 50));
      4: v = 32'd0 - 32'($urandom_range(1, 50));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic int rdy_edge();
    for (int k = 1; k <= NEDGE; k++) if (obs_rdy[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int rdy_count();
    int n = 0;
    for (int k = 1; k <= NEDGE; k++) if (obs_rdy[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int busy_errs(input int lat, input bit never);
    int e = 0;
    for (int k = 1; k <= NEDGE; k++)
      if (obs_busy[k] !== ((!never && k < lat) ? 1'b1 : 1'b0)) e++;
    return e;
  endfunction

  // Start edge is edge 0; obs[k] is what the DUT shows just before edge k
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input int inj_edge, input logic inj_m, input logic inj_d);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    for (int k = 1; k <= NEDGE; k++) begin
      @(negedge clock);
      obs_rdy[k] = data_resultRDY; obs_busy[k] = busy;
      obs_res[k] = data_result;    obs_exc[k]  = data_exception;
      ctrl_MULT = (k == inj_edge) ? inj_m : 1'b0;
      ctrl_DIV  = (k == inj_edge) ? inj_d : 1'b0;
    end
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ctrl_MULT = 1'b1; ctrl_DIV = 1'b0;
    data_operandA = 32'd3; data_operandB = 32'd3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    vectors++;
    if ({alu_opcode, alu_inA, alu_inB} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_alu_idle: got op=%b a=%h b=%h want 0", alu_opcode, alu_inA, alu_inB);
    end
    ctrl_MULT = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    logic [31:0] ta [0:2] = '{32'd6, 32'hFFFF_FFFD, 32'h0001_0000};
    logic [31:0] tb [0:2] = '{32'd7, 32'h0000_0005, 32'h0001_0000};
    logic [31:0] a, b;
    logic [32:0] exp;
    int re, idx;
    for (int i = 0; i < 23; i++) begin
      a = (i < 3) ? ta[i] : rnd_operand();
      b = (i < 3) ? tb[i] : rnd_operand();
      exp = ref_mult(a, b);
      do_op(1'b1, 1'b0, a, b, -1, 1'b0, 1'b0);
      re = rdy_edge(); idx = (re > 0) ? re : NEDGE;
      vectors++;
      if (re != 33 || rdy_count() != 1) begin
        miscompares++;
        $display("FAIL mult_latency %h*%h: got edge %0d count %0d want edge 33 count 1", a, b, re, rdy_count());
      end
      vectors++;
      if ({obs_res[idx], obs_exc[idx]} !== exp) begin
        miscompares++;
        $display("FAIL mult_result %h*%h: got %h/%b want %h/%b", a, b, obs_res[idx], obs_exc[idx], exp[32:1], exp[0]);
      end
      vectors++;
      if ({obs_res[NEDGE], obs_exc[NEDGE]} !== exp || busy_errs(33, 1'b0) != 0) begin
        miscompares++;
        $display("FAIL mult_hold_busy %h*%h: got %h/%b busy_errs %0d want %h/%b 0",
                 a, b, obs_res[NEDGE], obs_exc[NEDGE], busy_errs(33, 1'b0), exp[32:1], exp[0]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [0:3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd100};
    logic [31:0] tb [0:3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'd0, 32'd7};
    logic [31:0] a, b;
    logic [32:0] exp;
    int re, idx, lat;
    for (int i = 0; i < 28; i++) begin
      a = (i < 4) ? ta[i] : rnd_operand();
      b = (i < 4) ? tb[i] : rnd_operand();
      exp = ref_div(a, b);
      lat = (b == 32'd0) ? 1 : 34;
      do_op(1'b0, 1'b1, a, b, -1, 1'b0, 1'b0);
      re = rdy_edge(); idx = (re > 0) ? re : NEDGE;
      vectors++;
      if (re != lat || rdy_count() != 1) begin
        miscompares++;
        $display("FAIL div_latency %h/%h: got edge %0d count %0d want edge %0d count 1", a, b, re, rdy_count(), lat);
      end
      vectors++;
      if ({obs_res[idx], obs_exc[idx]} !== exp) begin
        miscompares++;
        $display("FAIL div_result %h/%h: got %h/%b want %h/%b", a, b, obs_res[idx], obs_exc[idx], exp[32:1], exp[0]);
      end
      vectors++;
      if ({obs_res[NEDGE], obs_exc[NEDGE]} !== exp || busy_errs(lat, b == 32'd0) != 0) begin
        miscompares++;
        $display("FAIL div_hold_busy %h/%h: got %h/%b busy_errs %0d want %h/%b 0",
                 a, b, obs_res[NEDGE], obs_exc[NEDGE], busy_errs(lat, b == 32'd0), exp[32:1], exp[0]);
      end
    end
  endtask

  task automatic test_priority();
    int re;
    do_op(1'b1, 1'b1, 32'd12, 32'd4, 10, 1'b0, 1'b1);
    re = rdy_edge();
    vectors++;
    if (re != 33 || rdy_count() != 1 || busy_errs(33, 1'b0) != 0) begin
      miscompares++;
      $display("FAIL priority_timing: got edge %0d count %0d busy_errs %0d want 33 1 0", re, rdy_count(), busy_errs(33, 1'b0));
    end
    vectors++;
    if ({obs_res[NEDGE], obs_exc[NEDGE]} !== {32'h30, 1'b0}) begin
      miscompares++;
      $display("FAIL priority_result: got %h/%b want 00000030/0", obs_res[NEDGE], obs_exc[NEDGE]);
    end
  endtask

  task automatic test_done_start();
    logic [31:0] a, b;
    logic [32:0] exp;
    a = $urandom; b = $urandom;
    exp = ref_mult(a, b);
    do_op(1'b1, 1'b0, a, b, 33, 1'b1, 1'b1);
    vectors++;
    if (rdy_count() != 1 || busy_errs(33, 1'b0) != 0 || {obs_res[NEDGE], obs_exc[NEDGE]} !== exp) begin
      miscompares++;
      $display("FAIL done_start_ignored: got count %0d busy_errs %0d res %h/%b want 1 0 %h/%b",
               rdy_count(), busy_errs(33, 1'b0), obs_res[NEDGE], obs_exc[NEDGE], exp[32:1], exp[0]);
    end
  endtask

  task automatic test_mid_reset();
    int rdy_seen = 0;
    int re;
    do_op(1'b1, 1'b0, 32'd6, 32'd7, -1, 1'b0, 1'b0);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd11;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) rdy_seen++;
      if (k == 10) reset = 1'b0;
      if (k == 11) begin
        reset = 1'b1;
        vectors++;
        if ({busy, data_resultRDY, data_result, data_exception} !== 35'd0) begin
          miscompares++;
          $display("FAIL mid_reset_clear: got busy=%b rdy=%b res=%h exc=%b want 0", busy, data_resultRDY, data_result, data_exception);
        end
      end
    end
    vectors++;
    if (rdy_seen != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_rdy: got %0d pulses want 0", rdy_seen);
    end
    do_op(1'b0, 1'b1, 32'd100, 32'd7, -1, 1'b0, 1'b0);
    re = rdy_edge();
    vectors++;
    if (re != 34 || obs_res[NEDGE] !== 32'h0E || obs_exc[NEDGE] !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_div: got edge %0d res %h exc %b want 34 0000000e 0", re, obs_res[NEDGE], obs_exc[NEDGE]);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    test_reset();
    test_mult();
    test_div();
    test_priority();
    test_done_start();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 SHALL have port: ctrl_MULT  input  1  start signed multiply; single-cycle pulse.
REQ-004 SHALL have port: ctrl_DIV  input  1  start signed divide; single-cycle pulse.
REQ-005 SHALL have port: data_operandA  input  32  multiplicand / dividend; sampled only on the start edge.
REQ-006 SHALL have port: data_operandB  input  32  multiplier / divisor; sampled only on the start edge.
REQ-007 SHALL have port: alu_opcode  output  5  operation for the shared ALU: 00000 ADD, 00001 SUB.
REQ-008 SHALL have port: alu_inA  output  32  shared ALU operand A.
REQ-009 SHALL have port: alu_inB  output  32  shared ALU operand B.
REQ-010 SHALL have port: alu_result  input  32  combinational ALU result for the current alu_opcode/alu_inA/alu_inB.
REQ-011 SHALL have port: data_result  output  32  registered result.
REQ-012 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag; valid with data_resultRDY.
REQ-013 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: busy  output  1  high while an operation is in flight.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIXUP and DONE.
REQ-016 SHALL, in IDLE, start a multiply when ctrl_MULT=1; ctrl_MULT SHALL win if ctrl_MULT and ctrl_DIV are both high.
REQ-017 SHALL ignore ctrl_MULT and ctrl_DIV whenever busy=1.
REQ-018 SHALL implement multiply as radix-2 Booth over 32 iterations in MUL, using a 65-bit internal product register {P_hi, P_lo, q-1}.
REQ-019 SHALL set each MUL step from bits {P_lo[0], q-1}: 01 -> ADD with multiplicand; 10 -> SUB of multiplicand; 00/11 -> ADD with alu_inB=0. The operation applies to P_hi, followed by an arithmetic right shift of the product register by 1.
REQ-020 SHALL make data_result equal to the low 32 bits of the product.
REQ-021 SHALL set data_exception=1 on multiply when the 64-bit product is not the sign extension of its low 32 bits.
REQ-022 SHALL perform divide in DIV as 32 restoring iterations on operand magnitudes, using ALU SUB for the trial subtract; magnitudes SHALL be formed internally on the start edge.
REQ-023 SHALL, in FIXUP (divide only), drive ALU SUB 0 - quotient when operand signs differ, else pass the quotient unchanged; the quotient SHALL truncate toward zero and the remainder SHALL be discarded.
REQ-024 SHALL treat divisor=0 as follows: go from IDLE to DONE directly, with data_result=0 and data_exception=1.
REQ-025 SHALL treat 0x80000000 / 0xFFFFFFFF as follows: data_result=0 and data_exception=1.
REQ-026 SHALL pulse data_resultRDY for exactly one cycle (DONE) with this latency, counted from the start edge as edge 0:
- multiply: edge 33;
- divide: edge 34;
- divide-by-zero: edge 1.
REQ-027 SHALL set busy=1 from the edge after the start edge until the DONE edge, inclusive of MUL/DIV/FIXUP states; busy SHALL be 0 in DONE and IDLE.
REQ-028 SHALL hold data_result and data_exception stable from DONE until the next accepted start.
REQ-029 SHALL make DONE return to IDLE unconditionally after one cycle; a start pulse coincident with DONE SHALL be ignored.
REQ-030 SHALL use a 6-bit iteration counter that is cleared on start and terminates the iteration state at count 32.
REQ-031 SHALL drive alu_opcode=00000 and alu_inA=alu_inB=0 in IDLE and DONE.

Reset
REQ-032 SHALL, while reset=0 at a rising edge, force state to IDLE and clear data_result, data_exception, data_resultRDY, busy, the counter and all internal registers.
REQ-033 SHALL abandon an in-flight operation on mid-operation reset with no RDY pulse; the first start after reset is released SHALL be accepted normally.

Verification
REQ-034 SHALL be verified by: MULT 6 x 7 -> data_result=0x0000002A, exception 0, RDY at edge 33 only.
REQ-035 SHALL be verified by: MULT 0xFFFFFFFD x 0x00000005 -> 0xFFFFFFF1, exception 0; MULT 0x00010000 x 0x00010000 -> exception 1, result 0x00000000.
REQ-036 SHALL be verified by: DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD, exception 0, RDY at edge 34; DIV 0x80000000 / 0xFFFFFFFF -> exception 1, result 0.
REQ-037 SHALL be verified by: DIV 5 / 0 -> result 0, exception 1, RDY at edge 1, busy never high.
REQ-038 SHALL be verified by: ctrl_MULT and ctrl_DIV both pulsed with A=12, B=4 -> result 0x30 (multiply), RDY at edge 33; a ctrl_DIV pulse at edge 10 -> ignored.
REQ-039 SHALL be verified by: reset=0 at edge 10 of a multiply -> next edge busy=0, RDY=0, result=0, no RDY pulse; then DIV 100/7 -> 0x0E at edge 34.
